// File: rtl/mod47_lut_arbiter.sv
// Round-robin arbiter sharing one external mod-47 constant-multiply LUT among N_REQ requesters.
// Latency: result registered 1 cycle after req_valid&req_ready; back-to-back accepts give 1 result/cycle.
// Backpressure: with the one-entry output buffer full and out_ready low, all req_ready bits are held low.
module mod47_lut_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 6,
    parameter int MOD   = 47,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [W-1:0]       lut_x,
    input  logic [W-1:0]       lut_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [IDW-1:0]     out_id,
    output logic               lut_err,
    input  logic               err_clr
);

    localparam logic [W-1:0]   MOD_W   = W'(MOD);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr;
    logic           can_accept;
    logic           accept;
    logic           hi_vld, lo_vld;
    logic [IDW-1:0] hi_id, lo_id, gnt_id;
    logic [W-1:0]   gnt_data, red_data;

    assign can_accept = (state_q == EMPTY) || out_ready;
    assign out_valid  = (state_q == FULL);

    // Lowest valid index at/above rr_ptr wins; otherwise wrap to the lowest valid index overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_id  = '0;
        lo_vld = 1'b0;
        lo_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_vld = 1'b1;
                lo_id  = IDW'(i);
                if (IDW'(i) >= rr_ptr) begin
                    hi_vld = 1'b1;
                    hi_id  = IDW'(i);
                end
            end
        end
    end

    assign gnt_id = hi_vld ? hi_id : lo_id;
    assign accept = can_accept && lo_vld;

    always_comb begin
        req_ready = '0;
        gnt_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                req_ready[i] = accept;
                gnt_data     = req_data[i*W +: W];
            end
        end
    end

    // One conditional subtract is enough since 2^W-1 < 2*MOD.
    assign red_data = (gnt_data >= MOD_W) ? (gnt_data - MOD_W) : gnt_data;
    assign lut_x    = accept ? red_data : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            rr_ptr   <= '0;
            out_data <= '0;
            out_id   <= '0;
            lut_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_data <= lut_z;
                out_id   <= gnt_id;
                rr_ptr   <= (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
            end
            // A new error outranks a simultaneous clear.
            if (accept && (lut_z >= MOD_W)) begin
                lut_err <= 1'b1;
            end else if (err_clr) begin
                lut_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod47_lut_arbiter.sv
// Bench for mod47_lut_arbiter: directed cases with literal expectations plus a randomized run
// checked every cycle against a behavioural round-robin/buffer model; LUT stub computes 3*x mod 47.
module tb_mod47_lut_arbiter;

    localparam int N   = 4;
    localparam int W   = 6;
    localparam int MOD = 47;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   lut_x;
    logic [W-1:0]   lut_z;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_id;
    logic           lut_err;
    logic           err_clr;
    logic           force_bad;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb lut_z = force_bad ? 6'd50 : 6'((3 * int'(lut_x)) % MOD);

    mod47_lut_arbiter #(.N_REQ(N), .W(W), .MOD(MOD), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .lut_x     (lut_x),
        .lut_z     (lut_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .lut_err   (lut_err),
        .err_clr   (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: buffer contents, pointer and error flag as plain integers.
    int         m_ptr, m_data, m_id;
    bit         m_vld, m_err;
    logic [N-1:0] last_rdy;

    always @(negedge clk) begin
        int g, d, red, ex, z, exp_rdy;
        bit can;
        last_rdy = req_ready;
        if (rst) begin
            m_ptr = 0; m_vld = 0; m_data = 0; m_id = 0; m_err = 0;
            check("m_rst_valid", out_valid, 0);
            check("m_rst_err", lut_err, 0);
            check("m_rst_ready", req_ready, 0);
        end else begin
            can = !m_vld || out_ready;
            g = -1;
            if (can) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            exp_rdy = (g >= 0) ? (1 << g) : 0;
            ex = 0;
            if (g >= 0) begin
                d   = int'(req_data[g*W +: W]);
                red = (d >= MOD) ? d - MOD : d;
                ex  = red;
            end
            check("m_req_ready", req_ready, exp_rdy);
            check("m_lut_x", lut_x, ex);
            check("m_out_valid", out_valid, m_vld);
            check("m_out_data", out_data, m_data);
            check("m_out_id", out_id, m_id);
            check("m_lut_err", lut_err, m_err);
            z = force_bad ? 50 : (3 * ex) % MOD;
            if (g >= 0 && z >= MOD) m_err = 1;
            else if (err_clr)       m_err = 0;
            if (g >= 0) begin
                m_vld = 1; m_data = z; m_id = g; m_ptr = (g + 1) % N;
            end else if (out_ready) begin
                m_vld = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; req_valid = '0; req_data = '0; out_ready = 1; err_clr = 0; force_bad = 0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_id", out_id, 0);
        check("rst_lut_err", lut_err, 0);
        step(); rst = 0;

        // Single request
        step(); req_valid = 4'b0001; req_data[0 +: W] = 6'd10; #2;
        check("t1_ready", req_ready, 4'b0001);
        check("t1_lut_x", lut_x, 10);
        step(); req_valid = '0; #2;
        check("t1_valid", out_valid, 1);
        check("t1_data", out_data, 30);
        check("t1_id", out_id, 0);

        // Pre-reduction
        step(); req_valid = 4'b0010; req_data[W +: W] = 6'd50; #2;
        check("t2_lut_x_50", lut_x, 3);
        check("t2_ready", req_ready, 4'b0010);
        step(); req_data[W +: W] = 6'd63; #2;
        check("t2_data_50", out_data, 9);
        check("t2_id", out_id, 1);
        check("t2_lut_x_63", lut_x, 16);
        step(); req_data[W +: W] = 6'd47; #2;
        check("t2_data_63", out_data, 1);
        check("t2_lut_x_47", lut_x, 0);
        step(); req_valid = '0; #2;
        check("t2_data_47", out_data, 0);

        // Round-robin with all requesters valid
        step(); rst = 1;
        step(); rst = 0;
        step(); req_valid = 4'hF;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 6'(5 + i);
        #2;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin step(); #2; end
            check("t3_grant", req_ready, 1 << (k % 4));
            if (k > 0) begin
                check("t3_valid", out_valid, 1);
                check("t3_id", out_id, (k - 1) % 4);
                check("t3_data", out_data, (3 * (5 + (k - 1) % 4)) % MOD);
            end
        end

        // Backpressure
        step(); out_ready = 0; #2;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin step(); #2; end
            check("t4_ready_blocked", req_ready, 0);
            check("t4_id_held", out_id, 1);
            check("t4_data_held", out_data, 18);
        end
        step(); out_ready = 1; #2;
        check("t4_next_grant", req_ready, 4'b0100);

        // Error flag
        step(); req_valid = 4'b0001; force_bad = 1; #2;
        check("t5_ready", req_ready, 4'b0001);
        step(); req_valid = '0; force_bad = 0; #2;
        check("t5_err_set", lut_err, 1);
        check("t5_data_fwd", out_data, 50);
        step(); #2;
        check("t5_err_sticky", lut_err, 1);
        step(); err_clr = 1;
        step(); err_clr = 0; #2;
        check("t5_err_cleared", lut_err, 0);
        step(); err_clr = 1; force_bad = 1; req_valid = 4'b0001;
        step(); err_clr = 0; force_bad = 0; req_valid = '0; #2;
        check("t5_set_wins", lut_err, 1);
        step(); err_clr = 1;
        step(); err_clr = 0;

        // Reset mid-operation
        step(); req_valid = 4'b0010;
        step(); req_valid = '0; out_ready = 0; #2;
        check("t6_pre_valid", out_valid, 1);
        check("t6_pre_id", out_id, 1);
        step(); rst = 1; #1;
        check("t6_async_valid", out_valid, 0);
        step(); rst = 0; out_ready = 1; req_valid = 4'hF; #2;
        check("t6_first_grant", req_ready, 4'b0001);

        // Randomized traffic; a waiting requester keeps its operand stable
        for (int n = 0; n < 3000; n++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_rdy[i]) begin
                    req_valid[i]        = ($urandom_range(0, 2) != 0);
                    req_data[i*W +: W]  = 6'($urandom_range(0, 63));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            force_bad = ($urandom_range(0, 19) == 0);
        end
        step();
        req_valid = '0; force_bad = 0; err_clr = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod47_lut_arbiter.md
Name: mod47_lut_arbiter

Overview:
- Shares one combinational 6-bit constant-multiply-mod-47 LUT (6 in, 6 out) between N_REQ requesters.
- The LUT instance is external to this block. The block drives its input and samples its output.
- Each request is a 6-bit operand. It is pre-reduced into [0,46], granted round-robin, looked up, and the result is registered in a one-entry output buffer tagged with the requester ID.
- Sits between the modular datapath clients and the shared LUT instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 6, operand/result width in bits.
- MOD, 47, modulus; operands and results are residues in [0, MOD-1].
- IDW, 2, requester ID width; must satisfy 2^IDW >= N_REQ.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  N_REQ*W  operands; requester i uses bits [i*W +: W].
- req_ready  out  N_REQ  one-hot grant/accept; combinational.
- lut_x  out  W  operand driven to the shared LUT; combinational.
- lut_z  in  W  LUT result, combinational from lut_x.
- out_valid  out  1  result buffer holds data.
- out_ready  in  1  downstream accept.
- out_data  out  W  registered LUT result.
- out_id  out  IDW  requester index of out_data.
- lut_err  out  1  sticky: the LUT returned a value >= MOD.
- err_clr  in  1  synchronous clear of lut_err.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_id=0, lut_err=0, rr_ptr=0, state=EMPTY. Reset mid-transaction discards the buffered result without raising an error.
- Pre-reduction: red_i = req_data_i - MOD if req_data_i >= MOD, else req_data_i. Examples: 47->0, 63->16. This is a single conditional subtract, which is valid because 2^W - 1 < 2*MOD.
- State machine (output buffer):
  - EMPTY: can_accept=1. On accept -> FULL.
  - FULL: can_accept = out_ready. If out_ready and accept, stay FULL and load the new result (back-to-back, 1 result/cycle). If out_ready and no accept -> EMPTY.
- Arbitration: when can_accept=1, grant the first i with req_valid[i]=1, scanning from rr_ptr upward with wrap at N_REQ.
  - req_ready[g]=1 only for the granted g; all other req_ready bits are 0.
  - When can_accept=0, all req_ready bits are 0.
  - req_ready depends on req_valid (grant), so requesters must not make req_valid depend on req_ready.
- On accept of requester g: rr_ptr <= (g+1) mod N_REQ. rr_ptr is unchanged when there is no accept.
- lut_x = red_g when a grant is active, else 0. This keeps LUT toggling low when idle.
- On accept: out_data <= lut_z, out_id <= g, out_valid <= 1.
- Latency: 1 cycle from the req_valid&req_ready edge to out_valid.
- out_data/out_id stay stable while out_valid=1 and out_ready=0.
- Error flag: on any accept with lut_z >= MOD, lut_err <= 1. The result is still forwarded unmodified.
- Simultaneous err_clr and a new error: set wins.
- A requester that holds req_valid with no grant must keep req_data stable; the block has no input buffering.
- Starvation bound: a continuously valid requester is granted within N_REQ accepts.

Test Plan (bench LUT stub: lut_z = (3*lut_x) mod 47):
1. Single request: after reset, req_valid=0001, data0=10 -> req_ready=0001 in the same cycle; next cycle out_valid=1, out_data=30, out_id=0.
2. Pre-reduction: data1=50 -> lut_x=3, out_data=9, out_id=1. data1=63 -> lut_x=16, out_data=1. data1=47 -> out_data=0.
3. Round-robin: all four valid continuously, out_ready=1 -> accepts in ID order 0,1,2,3,0,1. One result per cycle with no bubbles.
4. Backpressure: out_ready=0 with the buffer FULL for 3 cycles -> req_ready=0000; out_data/out_id held. Raise out_ready -> the next grant goes to the requester after the last granted one.
5. Error flag: stub forced to return 50 for one accept -> lut_err=1 from the next cycle and stays set. err_clr pulse -> 0. err_clr coinciding with another bad result -> lut_err stays 1.
6. Reset mid-operation: assert rst while out_valid=1 and rr_ptr=2 -> out_valid=0 immediately (asynchronous). After release, the first grant with all requesters valid goes to requester 0.
